// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file constants
// and the register-index type used by decode.
package reg_file_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AW       = $clog2(DEF_DEPTH);
  localparam int DEF_SP_INDEX = DEF_DEPTH - 1;
  localparam int DEF_SP_STEP  = 2;

  localparam logic [DEF_WIDTH-1:0] DEF_SP_RESET = 16'hFFFE;

  typedef logic [DEF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_cell.sv
// reg_cell: enable-gated register with a
// synchronous, parametrised reset value.
module reg_cell #(
  parameter int              WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // reset wins, otherwise load only when enabled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register bank, one write port,
// two combinational read ports, stepped stack pointer.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int              WIDTH    = DEF_WIDTH,
  parameter int              DEPTH    = DEF_DEPTH,
  parameter int              ZERO_REG = 1,
  parameter int              BYPASS   = 0,
  parameter int              SP_INDEX = DEPTH - 1,
  parameter int              SP_STEP  = DEF_SP_STEP,
  parameter logic [WIDTH-1:0] SP_RESET = {WIDTH{1'b1}} - 1'b1,
  localparam int             AW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Write,
  input  logic [AW-1:0]    WriteAddr,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [AW-1:0]    ReadAddrA,
  output logic [WIDTH-1:0] ReadDataA,
  input  logic [AW-1:0]    ReadAddrB,
  output logic [WIDTH-1:0] ReadDataB,
  input  logic             SPInc,
  input  logic             SPDec,
  output logic [WIDTH-1:0] SPValue
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] sp_d;
  logic             sp_en;
  logic             sp_wr;
  logic             wr_ok;

  // writes to a hard-wired zero register never land
  assign wr_ok = Write &&
    !((ZERO_REG != 0) && (WriteAddr == '0));

  assign sp_wr = wr_ok && (WriteAddr == AW'(SP_INDEX));
  assign sp_en = sp_wr || (SPInc ^ SPDec);

  // SP next value: explicit write beats a step
  always_comb begin
    sp_d = regs_q[SP_INDEX];
    if (sp_wr) begin
      sp_d = WriteData;
    end else if (SPInc && !SPDec) begin
      sp_d = regs_q[SP_INDEX] + WIDTH'(SP_STEP);
    end else if (SPDec && !SPInc) begin
      sp_d = regs_q[SP_INDEX] - WIDTH'(SP_STEP);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i == SP_INDEX) begin : g_sp
      reg_cell #(
        .WIDTH   (WIDTH),
        .RST_VAL (SP_RESET)
      ) u_cell (
        .clk_i (CLK),
        .rst_i (Reset),
        .en_i  (sp_en),
        .d_i   (sp_d),
        .q_o   (regs_q[i])
      );
    end else begin : g_gp
      logic en;
      assign en = wr_ok && (WriteAddr == AW'(i));
      reg_cell #(
        .WIDTH   (WIDTH),
        .RST_VAL ('0)
      ) u_cell (
        .clk_i (CLK),
        .rst_i (Reset),
        .en_i  (en),
        .d_i   (WriteData),
        .q_o   (regs_q[i])
      );
    end
  end

  assign SPValue = regs_q[SP_INDEX];

  // read port A: array, zero-reg mask, optional bypass
  always_comb begin
    ReadDataA = regs_q[ReadAddrA];
    if ((ZERO_REG != 0) && (ReadAddrA == '0)) begin
      ReadDataA = '0;
    end
    if ((BYPASS != 0) && wr_ok &&
        (ReadAddrA == WriteAddr)) begin
      ReadDataA = WriteData;
    end
  end

  // read port B: same structure as port A
  always_comb begin
    ReadDataB = regs_q[ReadAddrB];
    if ((ZERO_REG != 0) && (ReadAddrB == '0)) begin
      ReadDataB = '0;
    end
    if ((BYPASS != 0) && wr_ok &&
        (ReadAddrB == WriteAddr)) begin
      ReadDataB = WriteData;
    end
  end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised general-purpose register file for the 16-bit datapath, generalising the single write-enabled register into a bank of DEPTH registers of WIDTH bits. It provides one synchronous write port, two independent combinational read ports and an optional write-to-read bypass. A dedicated stack-pointer register supports single-cycle increment and decrement. It sits between instruction decode and the ALU operand muxes.

## Interface
- WIDTH, 16, bits per register.
- DEPTH, 16, number of registers; power of two, at least 4.
- AW, log2(DEPTH), address width; derived, not overridden.
- ZERO_REG, 1, if 1 then register 0 reads as 0 and ignores writes.
- BYPASS, 0, if 1 then a read of the address being written this cycle returns WriteData.
- SP_INDEX, DEPTH-1, index of the stack-pointer register.
- SP_STEP, 2, increment/decrement amount for the stack pointer.
- SP_RESET, {WIDTH{1'b1}} - 1 (16'hFFFE), reset value of the stack pointer.
- CLK  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Write  input  1  write enable for the write port.
- WriteAddr  input  AW  destination register index.
- WriteData  input  WIDTH  data to write.
- ReadAddrA  input  AW  read port A index.
- ReadDataA  output  WIDTH  read port A data.
- ReadAddrB  input  AW  read port B index.
- ReadDataB  output  WIDTH  read port B data.
- SPInc  input  1  add SP_STEP to the stack pointer.
- SPDec  input  1  subtract SP_STEP from the stack pointer.
- SPValue  output  WIDTH  current stack-pointer contents, always visible.

## Operation
- Reset (Reset=1 at a rising edge):
  - All registers clear to 0, except SP_INDEX, which loads SP_RESET.
  - Reset overrides Write, SPInc and SPDec in the same cycle.
  - Reset asserted mid-sequence discards any pending update.
- Write: when Write=1, register[WriteAddr] takes WriteData at the edge.
  - With ZERO_REG=1, a write to address 0 is dropped.
- Reads are purely combinational from the register array.
  - With ZERO_REG=1, address 0 returns 0.
  - With BYPASS=1, Write=1 and ReadAddrX==WriteAddr (and the address is not a dropped zero-register write), ReadDataX = WriteData.
  - Both ports may read the same address.
- Stack pointer:
  - SPInc=1 and SPDec=0: SP <= SP + SP_STEP.
  - SPDec=1 and SPInc=0: SP <= SP - SP_STEP.
  - SPInc and SPDec both 1: SP unchanged.
  - Arithmetic is modulo 2^WIDTH; 16'hFFFE + 2 wraps to 16'h0000, and 16'h0000 - 2 wraps to 16'hFFFE. No flags.
- Simultaneous Write to SP_INDEX with SPInc or SPDec: the explicit write wins and the step is discarded.
- Bypass with SPInc/SPDec: bypass applies only to the write port. The stepped SP value is visible on reads only from the next cycle.
- No hidden state beyond the register array. Undefined addresses cannot occur because DEPTH = 2^AW.

## Timing
- Write-to-read latency:
  - BYPASS=0: 1 cycle; the value is readable after the edge.
  - BYPASS=1: 0 cycles, through the combinational path.
- SPInc/SPDec: 1 cycle to SPValue and to the read ports.
- Read path is combinational: address-to-data within the same cycle. No registered outputs.
- Outputs after reset:
  - ReadDataA/B = 0 for every address except SP_INDEX, which returns SP_RESET.
  - SPValue = SP_RESET.

## Structure
- Shared package holds the default WIDTH, DEPTH, SP_INDEX, SP_STEP and SP_RESET constants, plus a register-index typedef of width AW for decode to share.
- Natural sub-module: reg_cell, a WIDTH-parametrised, enable-gated register with synchronous reset value parameter.
  - Instantiated DEPTH times via generate.
  - The SP cell gets its next-value mux (write / step / hold) outside reg_cell.
- Read muxes and bypass compare are in the top level.

## Test plan
- Reset: all registers at 0 except the SP; pulse Reset -> every ReadDataA at addresses 0..14 = 16'h0000, and address 15 and SPValue = 16'hFFFE.
- Write and hold: write 16'hFFFF to r3. Next cycle drive Write=0, WriteData=16'h1111 -> r3 still reads 16'hFFFF on both ports.
- Zero register: with ZERO_REG=1, write 16'hABCD to r0 -> ReadDataA(0) = 16'h0000 in all following cycles.
- Bypass: with BYPASS=1, Write=1, WriteAddr=5, WriteData=16'h1234, ReadAddrB=5 -> ReadDataB = 16'h1234 in the same cycle. With BYPASS=0 it shows the old value until the edge.
- SP wrap:
  - From reset, SPInc for 1 cycle -> SPValue = 16'h0000.
  - Then SPDec twice -> 16'hFFFC.
  - SPInc=SPDec=1 -> unchanged.
- Collisions:
  - Write=1 to SP_INDEX with 16'h0100 while SPInc=1 -> SPValue = 16'h0100.
  - Write to r7 with Reset=1 in the same cycle -> r7 reads 16'h0000.
